lsu_dccm_wbuf_mem: RTL
======================

Name: lsu_dccm_wbuf_mem

Overview:
- Next-generation banked DCCM data array for the LSU pipe.
- Parametrised in bank count, word width and depth.
- Adds a posted write buffer with read-over-write bank arbitration, read-after-write forwarding, and freeze-hold of read data.
- Sits between LSU DC1/DC2 address generation and the DC3 data alignment logic.

Parameters:
- DCCM_BITS, 16, byte-address width of the DCCM.
- NUM_BANKS, 8, number of banks; power of 2, ≥2.
- BYTE_WIDTH, 4, bytes per bank word; power of 2.
- FDATA_WIDTH, 39, stored word width (data+ECC), opaque to this block.
- WB_DEPTH, 2, write buffer entries; ≥1.
- Derived: WB = log2(BYTE_WIDTH); BANK_BITS = log2(NUM_BANKS); bank = addr[WB +: BANK_BITS]; index = addr[DCCM_BITS-1 : WB+BANK_BITS].

Ports:
- clk, input, 1, core clock; all flops on rising edge.
- rst_l, input, 1, asynchronous active-low reset.
- scan_mode, input, 1, test mode; functionally ignored.
- freeze, input, 1, pipeline freeze (DC3 freeze).
- wr_valid, input, 1, write request.
- wr_ready, output, 1, write buffer can accept.
- wr_addr, input, DCCM_BITS, write byte address.
- wr_data, input, FDATA_WIDTH, write word.
- rd_en, input, 1, read request.
- rd_addr_lo, input, DCCM_BITS, read address, low word.
- rd_addr_hi, input, DCCM_BITS, read address, high word (misaligned case).
- rd_data_lo, output, FDATA_WIDTH, read data for rd_addr_lo.
- rd_data_hi, output, FDATA_WIDTH, read data for rd_addr_hi.
- rd_valid, output, 1, read data valid.
- wb_count, output, $clog2(WB_DEPTH+1), occupied buffer entries.
- wb_empty, output, 1, wb_count==0.

Behaviour:
- Reset (async, rst_l=0):
  - wb_count=0; head/tail pointers=0; all entry valids=0.
  - rd_valid=0; rd_data_lo/hi=0.
  - wr_ready=1; wb_empty=1.
  - Array contents not reset.
  - Reset mid-operation discards all pending writes and any in-flight read.
- Read accept: rd_en & ~freeze.
  - Aligned (bank(lo)==bank(hi)): 1 bank accessed at index(lo).
  - Unaligned: bank(lo) at index(lo), and bank(hi) at index(hi).
  - Data on rd_data_lo/hi in the cycle after accept; rd_valid=1 that cycle.
  - Aligned: rd_data_hi == rd_data_lo.
- Cycle with no accepted read and ~freeze: rd_valid=0 next cycle; rd_data holds its last value.
- freeze=1: rd_valid and rd_data_lo/hi hold their previous values exactly, indefinitely. No array access, no drain.
- Write enqueue: wr_valid & wr_ready.
  - Entry {bank, index, data} written at tail; wb_count+1.
  - wr_ready = (wb_count < WB_DEPTH); it is a function of registered count only, not same-cycle drain.
  - Enqueue is allowed during freeze.
  - Write lands in the array no earlier than the cycle after enqueue.
- Drain: head entry written to its bank when ~freeze and head bank ∉ banks used by the read accepted this cycle.
  - At most one drain per cycle; wb_count−1.
  - Simultaneous enqueue+drain leaves wb_count unchanged.
- Forwarding: at read accept, each requested word (lo, hi) is compared {bank,index} against all valid entries.
  - The youngest match supplies the data in place of array output.
  - Matching includes the entry draining that same cycle and entries enqueued in earlier cycles.
  - A write enqueued in the same cycle as the read is not visible.
- Ordering: multiple writes to the same address drain in FIFO order; the array ends with the youngest.
- Pointers wrap modulo WB_DEPTH.
- Full: wr_ready=0 until a drain lowers the registered count.
- Read starvation of drain is permitted; no fairness counter.
- Clock gating: per-bank enable = (read bank | drain bank) & ~freeze.

Test Plan:
- Reset then write addr 0x0010 data 0x1_2345_6789 → wb_count 1→0 after 1 drain cycle. Then read 0x0010 → next cycle rd_valid=1, rd_data_lo=0x1_2345_6789.
- Enqueue 0x0020=A, then the next cycle read 0x0020 while rd_en continually targets bank 0 (blocks drain) → rd_data_lo=A via forwarding. wb_count stays 1 until rd_en drops, then 0.
- Unaligned read lo=0x001C (bank 7), hi=0x0020 (bank 0) with distinct preloaded words → rd_data_lo/hi return the two words. Aligned read 0x0024 → hi==lo.
- Fill buffer: 2 writes with freeze=1 → wr_ready=0, wb_count=2. Third wr_valid not accepted. Release freeze → two drains over ≥2 cycles, wr_ready=1 after first.
- Freeze asserted after read accept of X → rd_data_lo holds X and rd_valid holds 1 for 5 frozen cycles. No drain occurs.
- Two writes to 0x0040 (B then C) buffered, assert rst_l=0 mid-drain → wb_count=0, rd_valid=0 immediately. After reset, array at 0x0040 is B or old data, never C-before-B ordering violated.

Source files
------------

// File: rtl/lsu_dccm_wbuf_mem.sv
// Banked DCCM data array with a posted write buffer: reads win bank conflicts,
// buffered writes are forwarded to younger reads, and read data holds under freeze.
module lsu_dccm_wbuf_mem #(
    parameter int DCCM_BITS   = 16,
    parameter int NUM_BANKS   = 8,
    parameter int BYTE_WIDTH  = 4,
    parameter int FDATA_WIDTH = 39,
    parameter int WB_DEPTH    = 2,
    localparam int WB        = $clog2(BYTE_WIDTH),
    localparam int BANK_BITS = $clog2(NUM_BANKS),
    localparam int IDX_BITS  = DCCM_BITS - WB - BANK_BITS,
    localparam int CNT_BITS  = $clog2(WB_DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_l_i,
    input  logic                   scan_mode_i,
    input  logic                   freeze_i,
    input  logic                   wr_valid_i,
    output logic                   wr_ready_o,
    input  logic [DCCM_BITS-1:0]   wr_addr_i,
    input  logic [FDATA_WIDTH-1:0] wr_data_i,
    input  logic                   rd_en_i,
    input  logic [DCCM_BITS-1:0]   rd_addr_lo_i,
    input  logic [DCCM_BITS-1:0]   rd_addr_hi_i,
    output logic [FDATA_WIDTH-1:0] rd_data_lo_o,
    output logic [FDATA_WIDTH-1:0] rd_data_hi_o,
    output logic                   rd_valid_o,
    output logic [CNT_BITS-1:0]    wb_count_o,
    output logic                   wb_empty_o
);

    localparam int PTR_BITS   = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int BANK_DEPTH = 1 << IDX_BITS;

    // Circular increment; depth need not be a power of two.
    function automatic logic [PTR_BITS-1:0] next_ptr(input logic [PTR_BITS-1:0] p);
        if (p == PTR_BITS'(WB_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_BITS'(1);
        end
    endfunction

    // Slot holding the k-th oldest entry counted from head.
    function automatic logic [PTR_BITS-1:0] age_ptr(input logic [PTR_BITS-1:0] head, input int k);
        int s;
        s = int'(head) + k;
        if (s >= WB_DEPTH) begin
            s = s - WB_DEPTH;
        end else begin
            s = s;
        end
        return PTR_BITS'(s);
    endfunction

    logic [FDATA_WIDTH-1:0] mem_q [NUM_BANKS-1:0][BANK_DEPTH-1:0];

    logic [BANK_BITS-1:0]   wb_bank_q [WB_DEPTH];
    logic [IDX_BITS-1:0]    wb_idx_q  [WB_DEPTH];
    logic [FDATA_WIDTH-1:0] wb_data_q [WB_DEPTH];
    logic [WB_DEPTH-1:0]    wb_vld_q, wb_vld_d;
    logic [PTR_BITS-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_BITS-1:0]    count_q, count_d;

    logic                   rd_valid_q, rd_valid_d;
    logic [FDATA_WIDTH-1:0] rd_lo_q, rd_lo_d, rd_hi_q, rd_hi_d;

    logic [BANK_BITS-1:0]   bank_lo_s, bank_hi_s, bank_wr_s, head_bank_s;
    logic [IDX_BITS-1:0]    idx_lo_s, idx_hi_s, idx_wr_s;
    logic                   aligned_s, rd_acc_s, wr_ready_s, enq_s, drain_s;
    logic [NUM_BANKS-1:0]   bank_en_s;
    logic                   fwd_lo_hit_s, fwd_hi_hit_s;
    logic [FDATA_WIDTH-1:0] fwd_lo_s, fwd_hi_s, lo_word_s, hi_word_s;
    logic                   unused_s;

    assign unused_s = ^{scan_mode_i, wr_addr_i[WB-1:0], rd_addr_lo_i[WB-1:0], rd_addr_hi_i[WB-1:0]};

    assign bank_lo_s   = rd_addr_lo_i[WB +: BANK_BITS];
    assign bank_hi_s   = rd_addr_hi_i[WB +: BANK_BITS];
    assign bank_wr_s   = wr_addr_i[WB +: BANK_BITS];
    assign idx_lo_s    = rd_addr_lo_i[DCCM_BITS-1 -: IDX_BITS];
    assign idx_hi_s    = rd_addr_hi_i[DCCM_BITS-1 -: IDX_BITS];
    assign idx_wr_s    = wr_addr_i[DCCM_BITS-1 -: IDX_BITS];
    assign aligned_s   = (bank_lo_s == bank_hi_s);
    assign rd_acc_s    = rd_en_i & ~freeze_i;
    assign head_bank_s = wb_bank_q[head_q];

    // Ready depends only on the registered count, never on a same-cycle drain.
    assign wr_ready_s = (count_q < CNT_BITS'(WB_DEPTH));
    assign enq_s      = wr_valid_i & wr_ready_s;

    // Drain the head entry unless frozen or its bank is claimed by the accepted read.
    always_comb begin
        drain_s = 1'b0;
        if ((count_q != '0) && !freeze_i) begin
            if (rd_acc_s && ((head_bank_s == bank_lo_s) ||
                             (!aligned_s && (head_bank_s == bank_hi_s)))) begin
                drain_s = 1'b0;
            end else begin
                drain_s = 1'b1;
            end
        end else begin
            drain_s = 1'b0;
        end
    end

    // Per-bank access enable, doubling as the bank clock-gate condition.
    always_comb begin
        bank_en_s = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_en_s[b] = ((rd_acc_s && ((bank_lo_s == BANK_BITS'(b)) || (bank_hi_s == BANK_BITS'(b)))) ||
                            (drain_s && (head_bank_s == BANK_BITS'(b)))) && !freeze_i;
        end
    end

    // Walk entries oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_lo_hit_s = 1'b0;
        fwd_hi_hit_s = 1'b0;
        fwd_lo_s     = '0;
        fwd_hi_s     = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            logic [PTR_BITS-1:0] p;
            logic                m_lo, m_hi;
            p    = age_ptr(head_q, k);
            m_lo = wb_vld_q[p] && (wb_bank_q[p] == bank_lo_s) && (wb_idx_q[p] == idx_lo_s);
            m_hi = wb_vld_q[p] && (wb_bank_q[p] == bank_hi_s) && (wb_idx_q[p] == idx_hi_s);
            fwd_lo_hit_s = fwd_lo_hit_s | m_lo;
            fwd_hi_hit_s = fwd_hi_hit_s | m_hi;
            fwd_lo_s     = m_lo ? wb_data_q[p] : fwd_lo_s;
            fwd_hi_s     = m_hi ? wb_data_q[p] : fwd_hi_s;
        end
    end

    // An aligned access touches one bank word, so hi mirrors lo.
    assign lo_word_s = fwd_lo_hit_s ? fwd_lo_s : mem_q[bank_lo_s][idx_lo_s];
    assign hi_word_s = aligned_s ? lo_word_s :
                       (fwd_hi_hit_s ? fwd_hi_s : mem_q[bank_hi_s][idx_hi_s]);

    // Read result next-state: freeze holds everything, idle clears valid only.
    always_comb begin
        rd_valid_d = rd_valid_q;
        rd_lo_d    = rd_lo_q;
        rd_hi_d    = rd_hi_q;
        if (freeze_i) begin
            rd_valid_d = rd_valid_q;
        end else if (rd_en_i) begin
            rd_valid_d = 1'b1;
            rd_lo_d    = lo_word_s;
            rd_hi_d    = hi_word_s;
        end else begin
            rd_valid_d = 1'b0;
        end
    end

    // Write buffer pointer, valid and occupancy next-state.
    always_comb begin
        wb_vld_d = wb_vld_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        if (enq_s) begin
            wb_vld_d[tail_q] = 1'b1;
            tail_d           = next_ptr(tail_q);
        end else begin
            tail_d = tail_q;
        end
        if (drain_s) begin
            wb_vld_d[head_q] = 1'b0;
            head_d           = next_ptr(head_q);
        end else begin
            head_d = head_q;
        end
        case ({enq_s, drain_s})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset discards pending writes and any in-flight read.
    always_ff @(posedge clk_i or negedge rst_l_i) begin
        if (!rst_l_i) begin
            wb_vld_q   <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_lo_q    <= '0;
            rd_hi_q    <= '0;
        end else begin
            wb_vld_q   <= wb_vld_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_lo_q    <= rd_lo_d;
            rd_hi_q    <= rd_hi_d;
        end
    end

    // Entry payload is qualified by its valid bit, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (enq_s) begin
            wb_bank_q[tail_q] <= bank_wr_s;
            wb_idx_q[tail_q]  <= idx_wr_s;
            wb_data_q[tail_q] <= wr_data_i;
        end
    end

    // Array write port: retire the head entry into its bank.
    always_ff @(posedge clk_i) begin
        if (drain_s && bank_en_s[head_bank_s]) begin
            mem_q[head_bank_s][wb_idx_q[head_q]] <= wb_data_q[head_q];
        end
    end

    assign wr_ready_o   = wr_ready_s;
    assign wb_count_o   = count_q;
    assign wb_empty_o   = (count_q == '0);
    assign rd_valid_o   = rd_valid_q;
    assign rd_data_lo_o = rd_lo_q;
    assign rd_data_hi_o = rd_hi_q;

endmodule
